axi4_cmd_initiator: RTL and testbench



---
 rtl/axi4_cmd_pkg.sv | 16 +
 rtl/axi4_if.sv | 68 ++++++
 rtl/axi4_cmd_initiator.sv | 179 +++++++++++++++++
 tb/tb_axi4_cmd_initiator.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_cmd_pkg.sv
// Shared types and AXI encodings for the command-driven AXI4 initiator.
package axi4_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    AR,
    R,
    AW_W,
    B
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam int         RESP_SLVERR    = 1;

endpackage

// File: rtl/axi4_if.sv
// AXI4 bundle (32-bit data, 32-bit address) with master and slave views.
interface axi4_if #(
  parameter int ID_W = 4
);
  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awlock;
  logic [3:0]      awcache;
  logic [2:0]      awprot;
  logic [3:0]      awqos;
  logic            awvalid;
  logic            awready;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arlock;
  logic [3:0]      arcache;
  logic [2:0]      arprot;
  logic [3:0]      arqos;
  logic            arvalid;
  logic            arready;
  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi4_cmd_initiator.sv
// Turns a command/response handshake into one AXI4 read burst or single-beat write at a time.
// Optional AXI4_CMD_INITIATOR_IDCHK_EN flags RID/BID mismatches on rsp_err.
module axi4_cmd_initiator
  import axi4_cmd_pkg::*;
#(
  parameter int          AXI_ID_WIDTH = 4,
  parameter int unsigned AXI_ID       = 0
) (
  input  logic        clk_i,
  input  logic        rst_n,
  axi4_if.master      m,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [3:0]  cmd_len,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_last,
  output logic        rsp_err
);

  localparam logic [AXI_ID_WIDTH-1:0] ID_VAL = AXI_ID_WIDTH'(AXI_ID);

  state_t      state_reg;
  logic [31:0] addr_reg;
  logic [3:0]  len_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  beat_cnt_reg;
  logic        arvalid_reg;
  logic        awvalid_reg;
  logic        wvalid_reg;
  logic        aw_done_reg;
  logic        w_done_reg;
  logic        aw_hs;
  logic        w_hs;
  logic        id_err;

  assign aw_hs = awvalid_reg && m.awready;
  assign w_hs  = wvalid_reg && m.wready;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      len_reg      <= '0;
      wdata_reg    <= '0;
      beat_cnt_reg <= '0;
      arvalid_reg  <= 1'b0;
      awvalid_reg  <= 1'b0;
      wvalid_reg   <= 1'b0;
      aw_done_reg  <= 1'b0;
      w_done_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            addr_reg     <= {cmd_addr[31:2], 2'b00};
            len_reg      <= cmd_len;
            wdata_reg    <= cmd_wdata;
            beat_cnt_reg <= '0;
            aw_done_reg  <= 1'b0;
            w_done_reg   <= 1'b0;
            if (cmd_write) begin
              state_reg   <= AW_W;
              awvalid_reg <= 1'b1;
              wvalid_reg  <= 1'b1;
            end else begin
              state_reg   <= AR;
              arvalid_reg <= 1'b1;
            end
            // Bursts crossing a 4KB page are passed through untouched; flag them in simulation.
            assert (cmd_write || (({1'b0, cmd_addr[11:2]} + {7'b0, cmd_len}) <= 11'd1023))
              else $error("axi4_cmd_initiator: read burst crosses 4KB boundary");
          end
        end
        AR: begin
          if (m.arready) begin
            arvalid_reg <= 1'b0;
            state_reg   <= R;
          end
        end
        R: begin
          if (m.rvalid && rsp_ready) begin
            beat_cnt_reg <= beat_cnt_reg + 4'd1;
            assert (m.rlast == (beat_cnt_reg == len_reg))
              else $warning("axi4_cmd_initiator: RLAST disagrees with requested length");
            if (m.rlast) state_reg <= IDLE;
          end
        end
        AW_W: begin
          if (aw_hs) begin
            awvalid_reg <= 1'b0;
            aw_done_reg <= 1'b1;
          end
          if (w_hs) begin
            wvalid_reg <= 1'b0;
            w_done_reg <= 1'b1;
          end
          if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) state_reg <= B;
        end
        B: begin
          if (m.bvalid && rsp_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef AXI4_CMD_INITIATOR_IDCHK_EN
  logic id_mismatch_reg;

  assign id_err = ((state_reg == R) && (m.rid != ID_VAL)) ||
                  ((state_reg == B) && (m.bid != ID_VAL));

  // Sticky so a stray ID is still visible long after the offending beat.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      id_mismatch_reg <= 1'b0;
    end else if (rsp_valid && rsp_ready && id_err) begin
      id_mismatch_reg <= 1'b1;
    end
  end
`else
  assign id_err = 1'b0;
`endif

  assign cmd_ready = rst_n && (state_reg == IDLE);

  assign m.arid    = ID_VAL;
  assign m.araddr  = addr_reg;
  assign m.arlen   = {4'b0, len_reg};
  assign m.arsize  = AXI_SIZE_4B;
  assign m.arburst = AXI_BURST_INCR;
  assign m.arlock  = 1'b0;
  assign m.arcache = 4'b0;
  assign m.arprot  = 3'b0;
  assign m.arqos   = 4'b0;
  assign m.arvalid = arvalid_reg;

  assign m.awid    = ID_VAL;
  assign m.awaddr  = addr_reg;
  assign m.awlen   = 8'd0;
  assign m.awsize  = AXI_SIZE_4B;
  assign m.awburst = AXI_BURST_INCR;
  assign m.awlock  = 1'b0;
  assign m.awcache = 4'b0;
  assign m.awprot  = 3'b0;
  assign m.awqos   = 4'b0;
  assign m.awvalid = awvalid_reg;

  assign m.wdata  = wdata_reg;
  assign m.wstrb  = 4'hF;
  assign m.wlast  = 1'b1;
  assign m.wvalid = wvalid_reg;

  assign m.rready = (state_reg == R) && rsp_ready;
  assign m.bready = (state_reg == B) && rsp_ready;

  always_comb begin
    rsp_valid = 1'b0;
    rsp_data  = '0;
    rsp_last  = 1'b0;
    rsp_err   = 1'b0;
    if (state_reg == R) begin
      rsp_valid = m.rvalid;
      rsp_data  = m.rdata;
      rsp_last  = m.rlast;
      rsp_err   = m.rresp[RESP_SLVERR] || id_err;
    end else if (state_reg == B) begin
      rsp_valid = m.bvalid;
      rsp_last  = 1'b1;
      rsp_err   = m.bresp[RESP_SLVERR] || id_err;
    end
  end

endmodule

// File: tb/tb_axi4_cmd_initiator.sv
// Directed bench: the initial block plays the AXI slave and checks every step by hand-computed values.
module tb_axi4_cmd_initiator;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        rsp_err;

  int passed = 0;
  int total  = 0;
  int aw_cnt = 0;
  int w_cnt  = 0;

  axi4_if #(.ID_W(4)) axi ();

  axi4_cmd_initiator #(.AXI_ID_WIDTH(4), .AXI_ID(0)) dut (
    .clk_i     (clk_i),
    .rst_n     (rst_n),
    .m         (axi),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_last  (rsp_last),
    .rsp_err   (rsp_err)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (axi.awvalid && axi.awready) aw_cnt <= aw_cnt + 1;
    if (axi.wvalid && axi.wready)   w_cnt  <= w_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [3:0] len,
                       input logic [31:0] data);
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_wdata = data;
    cmd_valid = 1'b1;
    #1;
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    $display("cmd issued: write=%0d addr=0x%08h len=%0d data=0x%08h", wr, addr, len, data);
  endtask

  initial begin
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_addr    = '0;
    cmd_len     = '0;
    cmd_wdata   = '0;
    rsp_ready   = 1'b0;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    axi.bresp   = 2'b00;
    axi.bid     = 4'd0;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rdata   = '0;
    axi.rresp   = 2'b00;
    axi.rlast   = 1'b0;
    axi.rid     = 4'd0;

    // Reset state
    #2;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_arvalid", 32'(axi.arvalid), 32'd0);
    chk("rst_awvalid", 32'(axi.awvalid), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(posedge clk_i);
    #2 rst_n = 1'b1;
    #1;
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // 1: single-beat read, address low bits dropped
    issue(1'b0, 32'h0000_0003, 4'd0, 32'h0);
    chk("t1_arvalid", 32'(axi.arvalid), 32'd1);
    chk("t1_araddr", axi.araddr, 32'h0);
    chk("t1_arlen", 32'(axi.arlen), 32'd0);
    chk("t1_arsize", 32'(axi.arsize), 32'd2);
    chk("t1_arburst", 32'(axi.arburst), 32'd1);
    chk("t1_cmd_ready_busy", 32'(cmd_ready), 32'd0);
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    chk("t1_arvalid_drop", 32'(axi.arvalid), 32'd0);
    axi.rvalid = 1'b1; axi.rdata = 32'h2; axi.rlast = 1'b1; rsp_ready = 1'b1;
    #1;
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t1_rsp_data", rsp_data, 32'h2);
    chk("t1_rsp_last", 32'(rsp_last), 32'd1);
    chk("t1_rsp_err", 32'(rsp_err), 32'd0);
    chk("t1_rready", 32'(axi.rready), 32'd1);
    tick();
    axi.rvalid = 1'b0; axi.rlast = 1'b0; rsp_ready = 1'b0;
    chk("t1_cmd_ready_back", 32'(cmd_ready), 32'd1);

    // 2: 4-beat burst with AR held and a 2-cycle rsp_ready stall
    issue(1'b0, 32'h0000_0100, 4'd3, 32'h0);
    tick();
    chk("t2_arvalid_held", 32'(axi.arvalid), 32'd1);
    chk("t2_araddr", axi.araddr, 32'h100);
    chk("t2_arlen", 32'(axi.arlen), 32'd3);
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      axi.rvalid = 1'b1;
      axi.rdata  = 32'hA0 + 32'(i);
      axi.rlast  = (i == 3);
      if (i == 2) begin
        rsp_ready = 1'b0;
        for (int s = 0; s < 2; s++) begin
          #1;
          chk("t2_stall_rready", 32'(axi.rready), 32'd0);
          tick();
        end
      end
      rsp_ready = 1'b1;
      #1;
      chk("t2_beat_data", rsp_data, 32'hA0 + 32'(i));
      chk("t2_beat_last", 32'(rsp_last), (i == 3) ? 32'd1 : 32'd0);
      chk("t2_beat_rready", 32'(axi.rready), 32'd1);
      tick();
    end
    axi.rvalid = 1'b0; axi.rlast = 1'b0; rsp_ready = 1'b0;
    chk("t2_cmd_ready_back", 32'(cmd_ready), 32'd1);

    // 3: write with AW and W accepted together
    issue(1'b1, 32'h0000_000C, 4'd5, 32'h1);
    chk("t3_awvalid", 32'(axi.awvalid), 32'd1);
    chk("t3_wvalid", 32'(axi.wvalid), 32'd1);
    chk("t3_awaddr", axi.awaddr, 32'hC);
    chk("t3_awlen", 32'(axi.awlen), 32'd0);
    chk("t3_wdata", axi.wdata, 32'h1);
    chk("t3_wstrb", 32'(axi.wstrb), 32'hF);
    chk("t3_wlast", 32'(axi.wlast), 32'd1);
    axi.awready = 1'b1; axi.wready = 1'b1;
    tick();
    axi.awready = 1'b0; axi.wready = 1'b0;
    chk("t3_awvalid_drop", 32'(axi.awvalid), 32'd0);
    chk("t3_wvalid_drop", 32'(axi.wvalid), 32'd0);
    axi.bvalid = 1'b1; axi.bresp = 2'b00; rsp_ready = 1'b1;
    #1;
    chk("t3_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t3_rsp_err", 32'(rsp_err), 32'd0);
    chk("t3_rsp_last", 32'(rsp_last), 32'd1);
    chk("t3_rsp_data", rsp_data, 32'h0);
    chk("t3_bready", 32'(axi.bready), 32'd1);
    chk("t3_cmd_ready_in_b", 32'(cmd_ready), 32'd0);
    tick();
    axi.bvalid = 1'b0; rsp_ready = 1'b0;
    chk("t3_cmd_ready_back", 32'(cmd_ready), 32'd1);
    chk("t3_aw_count", 32'(aw_cnt), 32'd1);
    chk("t3_w_count", 32'(w_cnt), 32'd1);

    // 4a: W accepted three cycles before AW
    issue(1'b1, 32'h0000_0020, 4'd0, 32'hBEEF);
    axi.wready = 1'b1;
    tick();
    axi.wready = 1'b0;
    chk("t4a_wvalid_drop", 32'(axi.wvalid), 32'd0);
    chk("t4a_awvalid_hold", 32'(axi.awvalid), 32'd1);
    tick();
    tick();
    chk("t4a_awvalid_hold2", 32'(axi.awvalid), 32'd1);
    chk("t4a_no_b_yet", 32'(axi.bready), 32'd0);
    axi.awready = 1'b1;
    tick();
    axi.awready = 1'b0;
    chk("t4a_awvalid_drop", 32'(axi.awvalid), 32'd0);
    axi.bvalid = 1'b1; rsp_ready = 1'b1;
    #1;
    chk("t4a_rsp_valid", 32'(rsp_valid), 32'd1);
    tick();
    axi.bvalid = 1'b0; rsp_ready = 1'b0;
    chk("t4a_aw_count", 32'(aw_cnt), 32'd2);
    chk("t4a_w_count", 32'(w_cnt), 32'd2);

    // 4b: AW accepted three cycles before W
    issue(1'b1, 32'h0000_0024, 4'd0, 32'hCAFE);
    axi.awready = 1'b1;
    tick();
    axi.awready = 1'b0;
    chk("t4b_awvalid_drop", 32'(axi.awvalid), 32'd0);
    chk("t4b_wvalid_hold", 32'(axi.wvalid), 32'd1);
    tick();
    tick();
    chk("t4b_wvalid_hold2", 32'(axi.wvalid), 32'd1);
    chk("t4b_wdata", axi.wdata, 32'hCAFE);
    axi.wready = 1'b1;
    tick();
    axi.wready = 1'b0;
    chk("t4b_wvalid_drop", 32'(axi.wvalid), 32'd0);
    axi.bvalid = 1'b1; rsp_ready = 1'b1;
    tick();
    axi.bvalid = 1'b0; rsp_ready = 1'b0;
    chk("t4b_aw_count", 32'(aw_cnt), 32'd3);
    chk("t4b_w_count", 32'(w_cnt), 32'd3);
    chk("t4b_cmd_ready_back", 32'(cmd_ready), 32'd1);

    // 5a: SLVERR write response
    issue(1'b1, 32'h0000_0040, 4'd0, 32'h5);
    axi.awready = 1'b1; axi.wready = 1'b1;
    tick();
    axi.awready = 1'b0; axi.wready = 1'b0;
    axi.bvalid = 1'b1; axi.bresp = 2'b10; rsp_ready = 1'b1;
    #1;
    chk("t5_bresp_err", 32'(rsp_err), 32'd1);
    tick();
    axi.bvalid = 1'b0; axi.bresp = 2'b00; rsp_ready = 1'b0;

    // 5b: reset asserted while in R
    issue(1'b0, 32'h0000_0200, 4'd1, 32'h0);
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    axi.rvalid = 1'b1; axi.rdata = 32'h77; rsp_ready = 1'b1;
    #1;
    chk("t5_rready_pre_rst", 32'(axi.rready), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rready_rst", 32'(axi.rready), 32'd0);
    chk("t5_rsp_valid_rst", 32'(rsp_valid), 32'd0);
    chk("t5_arvalid_rst", 32'(axi.arvalid), 32'd0);
    chk("t5_cmd_ready_rst", 32'(cmd_ready), 32'd0);
    axi.rvalid = 1'b0; rsp_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("t5_cmd_ready_release", 32'(cmd_ready), 32'd1);

    // 6: wrong RID on a read beat
    issue(1'b0, 32'h0000_0300, 4'd0, 32'h0);
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    axi.rvalid = 1'b1; axi.rdata = 32'h55; axi.rlast = 1'b1; axi.rid = 4'd1; rsp_ready = 1'b1;
    #1;
    chk("t6_rid_data", rsp_data, 32'h55);
`ifdef AXI4_CMD_INITIATOR_IDCHK_EN
    chk("t6_rid_err", 32'(rsp_err), 32'd1);
`else
    chk("t6_rid_err", 32'(rsp_err), 32'd0);
`endif
    tick();
    axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rid = 4'd0; rsp_ready = 1'b0;
    chk("t6_cmd_ready_back", 32'(cmd_ready), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
